// File: rtl/switch_bounce_generator_if.sv
// Command/observation bundle for switch_bounce_generator.
// master: drives cmd_valid/cmd_level, observes cmd_ready, bounce_out, busy, last_bounce_cycles.
// slave:  the generator side; cmd_ready is the only backpressure (low while a burst or hold runs).
interface switch_bounce_generator_if #(
  parameter int STAT_BITS = 24
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_level;
  logic                 bounce_out;
  logic                 busy;
  logic [STAT_BITS-1:0] last_bounce_cycles;

  modport master (
    output cmd_valid,
    output cmd_level,
    input  cmd_ready,
    input  bounce_out,
    input  busy,
    input  last_bounce_cycles
  );

  modport slave (
    input  cmd_valid,
    input  cmd_level,
    output cmd_ready,
    output bounce_out,
    output busy,
    output last_bounce_cycles
  );
endinterface

// File: rtl/switch_bounce_generator.sv
// Turns clean level-change commands into a deterministic bouncing switch waveform (2*BOUNCE_PULSES+1 edges).
// Latency: first edge one clock after acceptance; later edges one interval apart; HOLD_CYCLES settle before next command.
// Backpressure: cmd_ready is high only in IDLE; commands in BOUNCE/HOLD wait. Define SWITCH_BOUNCE_GEN_RANDOM_EN for LFSR intervals.
//
// Ports: clock, reset (async, active-high), cmd (slave modport): cmd_valid/cmd_ready/cmd_level command handshake,
//        bounce_out registered switch output, busy (BOUNCE or HOLD), last_bounce_cycles first-to-final-edge span.
module switch_bounce_generator #(
  parameter bit          INITIAL_LEVEL         = 1'b0,
  parameter int          BOUNCE_PULSES         = 3,
  parameter int          FIXED_INTERVAL_CYCLES = 100,
  parameter int          INTERVAL_BITS         = 8,
  parameter logic [15:0] LFSR_SEED             = 16'hACE1,
  parameter int          HOLD_CYCLES           = 1000,
  parameter int          STAT_BITS             = 24
) (
  input  logic                     clock,
  input  logic                     reset,
  switch_bounce_generator_if.slave cmd
);

  localparam int RAND_MAX = 1 << INTERVAL_BITS;
  localparam int INT_MAX  = (FIXED_INTERVAL_CYCLES > RAND_MAX) ? FIXED_INTERVAL_CYCLES : RAND_MAX;
  localparam int INT_W    = $clog2(INT_MAX + 1);
  localparam int HOLD_W   = $clog2(HOLD_CYCLES + 1);
  localparam int EDGE_W   = 9;  // holds 2*255

  localparam logic [STAT_BITS-1:0] SPAN_MAX = {STAT_BITS{1'b1}};

  // Reject parameter sets the datapath cannot represent.
  if (FIXED_INTERVAL_CYCLES < 1 || HOLD_CYCLES < 1 || BOUNCE_PULSES < 0 ||
      BOUNCE_PULSES > 255 || LFSR_SEED == 16'h0000) begin : g_bad_params
    $error("switch_bounce_generator: illegal parameter value");
  end

  typedef enum logic [1:0] {
    IDLE,
    BOUNCE,
    HOLD
  } state_t;

  state_t               state;
  logic [INT_W-1:0]     int_cnt;
  logic [EDGE_W-1:0]    edges_left;
  logic [HOLD_W-1:0]    hold_cnt;
  logic [STAT_BITS-1:0] span_cnt;
  logic [STAT_BITS-1:0] span_inc;
  logic [INT_W-1:0]     interval_load;
  logic                 accept_go;
  logic                 int_expire;

  // Only a command that actually changes the level starts a burst; matching levels are consumed in place.
  assign accept_go  = (state == IDLE) && cmd.cmd_ready && cmd.cmd_valid &&
                      (cmd.cmd_level != cmd.bounce_out);
  assign int_expire = (state == BOUNCE) && (int_cnt == INT_W'(1));

  // Span saturates so a very long burst reports all-ones instead of wrapping.
  assign span_inc = (span_cnt == SPAN_MAX) ? span_cnt : span_cnt + 1'b1;

`ifdef SWITCH_BOUNCE_GEN_RANDOM_EN
  // Galois LFSR, stepped only when an interval is loaded so bursts are reproducible from reset.
  // The reload on the final edge also steps it, keeping the load pattern uniform for every edge.
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;

  assign lfsr_next     = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
  assign interval_load = INT_W'({1'b0, lfsr[INTERVAL_BITS-1:0]} + 1'b1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else if (accept_go || int_expire) begin
      lfsr <= lfsr_next;
    end
  end
`else
  assign interval_load = INT_W'(FIXED_INTERVAL_CYCLES);
`endif

  // Interval counter counts down to 1: an edge at clock E with load I puts the next edge at E+I.
  // Span is cleared on the first edge and counts BOUNCE clocks, so at the final edge it equals the edge distance.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                  <= IDLE;
      cmd.bounce_out         <= INITIAL_LEVEL;
      cmd.cmd_ready          <= 1'b0;
      cmd.busy               <= 1'b0;
      cmd.last_bounce_cycles <= '0;
      int_cnt                <= '0;
      edges_left             <= '0;
      hold_cnt               <= '0;
      span_cnt               <= '0;
    end else begin
      case (state)
        IDLE: begin
          cmd.cmd_ready <= 1'b1;
          if (accept_go) begin
            cmd.bounce_out <= ~cmd.bounce_out;
            edges_left     <= EDGE_W'(2 * BOUNCE_PULSES);
            int_cnt        <= interval_load;
            span_cnt       <= '0;
            cmd.cmd_ready  <= 1'b0;
            cmd.busy       <= 1'b1;
            if (BOUNCE_PULSES == 0) begin
              cmd.last_bounce_cycles <= '0;
              hold_cnt               <= HOLD_W'(HOLD_CYCLES);
              state                  <= HOLD;
            end else begin
              state <= BOUNCE;
            end
          end
        end

        BOUNCE: begin
          span_cnt <= span_inc;
          if (int_expire) begin
            cmd.bounce_out <= ~cmd.bounce_out;
            edges_left     <= edges_left - 1'b1;
            int_cnt        <= interval_load;
            if (edges_left == EDGE_W'(1)) begin
              cmd.last_bounce_cycles <= span_inc;
              hold_cnt               <= HOLD_W'(HOLD_CYCLES);
              state                  <= HOLD;
            end
          end else begin
            int_cnt <= int_cnt - 1'b1;
          end
        end

        HOLD: begin
          if (hold_cnt == HOLD_W'(1)) begin
            cmd.cmd_ready <= 1'b1;
            cmd.busy      <= 1'b0;
            state         <= IDLE;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_switch_bounce_generator.sv
module tb_switch_bounce_generator;

  localparam int P     = 3;
  localparam int FIXED = 100;
  localparam int HOLD  = 1000;
  localparam int HOLD1 = 20;
  localparam logic [15:0] SEED = 16'hACE1;

`ifdef SWITCH_BOUNCE_GEN_RANDOM_EN
  localparam bit RAND_MODE = 1'b1;
`else
  localparam bit RAND_MODE = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  switch_bounce_generator_if #(.STAT_BITS(24)) bus0 ();
  switch_bounce_generator_if #(.STAT_BITS(24)) bus1 ();

  switch_bounce_generator #(
    .INITIAL_LEVEL(1'b0), .BOUNCE_PULSES(P), .FIXED_INTERVAL_CYCLES(FIXED), .INTERVAL_BITS(8),
    .LFSR_SEED(SEED), .HOLD_CYCLES(HOLD), .STAT_BITS(24)
  ) dut0 (.clock(clock), .reset(reset), .cmd(bus0.slave));

  switch_bounce_generator #(
    .INITIAL_LEVEL(1'b0), .BOUNCE_PULSES(0), .FIXED_INTERVAL_CYCLES(FIXED), .INTERVAL_BITS(8),
    .LFSR_SEED(SEED), .HOLD_CYCLES(HOLD1), .STAT_BITS(24)
  ) dut1 (.clock(clock), .reset(reset), .cmd(bus1.slave));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard of expected edges: absolute cycle and level after the edge.
  typedef struct { int t; logic lvl; } edge_t;
  edge_t exp_q[$];

  logic        mdl_out   = 1'b0;
  logic        prev_out  = 1'b0;
  bit          mon_en    = 1'b0;
  logic        model_lvl = 1'b0;
  logic [15:0] lfsr_m    = SEED;

  // Compare whenever the DUT or the model moves: catches missing, late, early and extra edges.
  always @(negedge clock) begin : mon
    bit exp_edge;
    exp_edge = mon_en && (exp_q.size() > 0) && (exp_q[0].t == cyc);
    if (exp_edge) begin
      mdl_out = exp_q[0].lvl;
      void'(exp_q.pop_front());
    end
    if (mon_en && (exp_edge || bus0.bounce_out !== prev_out))
      chk("bounce_out_edge", bus0.bounce_out, mdl_out);
    prev_out = bus0.bounce_out;
  end

  function automatic int next_interval();
    int iv;
    if (!RAND_MODE) return FIXED;
    iv = int'(lfsr_m[7:0]) + 1;
    lfsr_m = lfsr_m[0] ? ((lfsr_m >> 1) ^ 16'hB400) : (lfsr_m >> 1);
    return iv;
  endfunction

  // Called on the negedge where a level-changing command is presented; acceptance at the next posedge.
  task automatic launch(input logic lvl, output int f_cyc, output int span);
    int t;
    int iv;
    t    = cyc + 1;
    span = 0;
    exp_q.push_back('{t, lvl});
    for (int k = 1; k <= 2 * P; k++) begin
      iv = next_interval();
      t += iv;
      span += iv;
      exp_q.push_back('{t, lvl ^ k[0]});
    end
    void'(next_interval());  // reload on the final edge
    f_cyc     = t;
    model_lvl = lvl;
  endtask

  task automatic apply_cmd(input logic lvl, input bit go, input int exp_last, input string tag);
    int f_cyc;
    int span;
    int want_last;
    chk({tag, "_ready_before"}, bus0.cmd_ready, 1);
    bus0.cmd_valid = 1'b1;
    bus0.cmd_level = lvl;
    if (go) launch(lvl, f_cyc, span);
    @(negedge clock);
    bus0.cmd_valid = 1'b0;
    if (go) begin
      want_last = RAND_MODE ? span : exp_last;
      chk({tag, "_busy_rise"}, bus0.busy, 1);
      chk({tag, "_ready_low"}, bus0.cmd_ready, 0);
      repeat (f_cyc - cyc) @(negedge clock);
      chk({tag, "_last_span"}, bus0.last_bounce_cycles, want_last);
      chk({tag, "_final_lvl"}, bus0.bounce_out, lvl);
      repeat (HOLD - 1) @(negedge clock);
      chk({tag, "_ready_hold"}, bus0.cmd_ready, 0);
      chk({tag, "_busy_hold"}, bus0.busy, 1);
      @(negedge clock);
      chk({tag, "_ready_back"}, bus0.cmd_ready, 1);
      chk({tag, "_busy_fall"}, bus0.busy, 0);
    end else begin
      chk({tag, "_noop_busy"}, bus0.busy, 0);
      chk({tag, "_noop_ready"}, bus0.cmd_ready, 1);
      chk({tag, "_noop_lvl"}, bus0.bounce_out, model_lvl);
    end
  endtask

  typedef struct { logic lvl; bit go; int last; } vec_t;
  vec_t vecs[5];

  initial begin
    #(1_000_000);
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int f_cyc;
    int span;
    int t3;

    vecs[0] = '{1'b1, 1'b1, 600};
    vecs[1] = '{1'b1, 1'b0, 0};
    vecs[2] = '{1'b0, 1'b1, 600};
    vecs[3] = '{1'b0, 1'b0, 0};
    vecs[4] = '{1'b1, 1'b1, 600};

    bus0.cmd_valid = 1'b0; bus0.cmd_level = 1'b0;
    bus1.cmd_valid = 1'b0; bus1.cmd_level = 1'b0;

    // Reset values while reset is held.
    #1 reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_bounce_out", bus0.bounce_out, 0);
    chk("rst_busy", bus0.busy, 0);
    chk("rst_ready", bus0.cmd_ready, 0);
    chk("rst_last", bus0.last_bounce_cycles, 0);
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clock);
    chk("idle_ready", bus0.cmd_ready, 1);

    // Zero-pulse instance: one edge, span 0, HOLD, back to IDLE.
    chk("p0_ready", bus1.cmd_ready, 1);
    bus1.cmd_valid = 1'b1;
    bus1.cmd_level = 1'b1;
    @(negedge clock);
    bus1.cmd_valid = 1'b0;
    chk("p0_edge", bus1.bounce_out, 1);
    chk("p0_busy", bus1.busy, 1);
    chk("p0_ready_low", bus1.cmd_ready, 0);
    chk("p0_last", bus1.last_bounce_cycles, 0);
    repeat (HOLD1 - 1) @(negedge clock);
    chk("p0_hold_lvl", bus1.bounce_out, 1);
    chk("p0_hold_ready", bus1.cmd_ready, 0);
    @(negedge clock);
    chk("p0_ready_back", bus1.cmd_ready, 1);
    chk("p0_busy_fall", bus1.busy, 0);

    // Table of commands on the default instance.
    for (int i = 0; i < 5; i++)
      apply_cmd(vecs[i].lvl, vecs[i].go, vecs[i].last, $sformatf("vec%0d", i));

    // cmd_valid held through BOUNCE and HOLD with a toggling level: only the IDLE-cycle value counts.
    chk("holdoff_ready", bus0.cmd_ready, 1);
    bus0.cmd_valid = 1'b1;
    bus0.cmd_level = ~model_lvl;
    launch(~model_lvl, f_cyc, span);
    @(negedge clock);
    while (cyc < f_cyc + HOLD) begin
      bus0.cmd_level = ~bus0.cmd_level;
      @(negedge clock);
    end
    chk("holdoff_ready_back", bus0.cmd_ready, 1);
    chk("holdoff_last", bus0.last_bounce_cycles, RAND_MODE ? span : 600);
    bus0.cmd_level = model_lvl;  // accepted as a no-op
    @(negedge clock);
    bus0.cmd_valid = 1'b0;
    chk("holdoff_busy", bus0.busy, 0);
    chk("holdoff_ready_after", bus0.cmd_ready, 1);
    repeat (3) @(negedge clock);

    // Reset in the middle of a burst, just after the third edge.
    bus0.cmd_valid = 1'b1;
    bus0.cmd_level = 1'b1;
    launch(1'b1, f_cyc, span);
    t3 = exp_q[2].t;
    @(negedge clock);
    bus0.cmd_valid = 1'b0;
    repeat (t3 + 3 - cyc) @(negedge clock);
    chk("pre_rst_lvl", bus0.bounce_out, 1);
    #2 reset = 1'b1;
    mon_en = 1'b0;
    #1;
    chk("midrst_bounce_out", bus0.bounce_out, 0);
    chk("midrst_busy", bus0.busy, 0);
    chk("midrst_ready", bus0.cmd_ready, 0);
    chk("midrst_last", bus0.last_bounce_cycles, 0);
    exp_q.delete();
    mdl_out   = 1'b0;
    model_lvl = 1'b0;
    lfsr_m    = SEED;
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    mon_en = 1'b1;
    apply_cmd(1'b1, 1'b1, 600, "post_rst");

    repeat (5) @(negedge clock);
    chk("edges_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
